segmod: RTL and testbench
=========================

Name: segmod

Overview:
- Seconds counter and carry source feeding the minute counter's `seg` input.
- Divides `clk` down to a 1 Hz tick and counts seconds 0..59.
- On rollover it presents `seg`==60 for exactly one clock, then returns to 0. The minute counter's 60-detect then increments minutes exactly once.
- Also accepts manual second up/down adjust pulses from the button logic.

Parameters:
- PRESCALE, 10000, clk cycles per second. Legal values are 2 or greater.
- SEC_WRAP, 60, value presented for one cycle as the minute carry. Values in normal counting are 0..SEC_WRAP-1.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- enable  input  1  run prescaler; when low, time is frozen
- up_seg  input  1  one-cycle pulse: +1 second
- down_seg  input  1  one-cycle pulse: -1 second
- seg  output  32  current seconds value, 0..SEC_WRAP; upper bits always 0
- sec_tick  output  1  registered one-cycle pulse, the cycle after each prescaler expiry
- carry  output  1  high exactly while seg==SEC_WRAP

Behaviour:
- Reset (reset low, asynchronous):
  - seg=0, sec_tick=0, carry=0.
  - Prescaler count=0, state=COUNT, pending=0.
  - Release is synchronous to clk in effect; first count on the following edge.
- Prescaler:
  - pre is a $clog2(PRESCALE)-bit counter that increments only when enable=1.
  - When pre==PRESCALE-1: pre<=0 and internal tick=1 for that cycle.
  - When enable=0, pre holds its value and no ticks are produced.
  - sec_tick<=tick, i.e. 1-cycle latency after the tick.
- States:
  - COUNT, normal counting.
  - CARRY, lasting one cycle while seg==SEC_WRAP.
- COUNT, increment event = tick OR up_seg. Simultaneous tick+up_seg produces a single +1.
  - Increment with seg==SEC_WRAP-1: seg<=SEC_WRAP, go to CARRY.
  - Increment with seg<SEC_WRAP-1: seg<=seg+1.
  - Else if down_seg with seg==0: seg<=SEC_WRAP-1. Wraps with no borrow from minutes.
  - Else if down_seg: seg<=seg-1.
  - Increment has priority over down_seg when both occur in the same cycle.
  - If pending=1: apply it as an increment this cycle and clear it. A new tick in the same cycle still counts only once.
- CARRY:
  - Always lasts exactly one cycle: seg<=0, state<=COUNT.
  - A tick arriving here sets pending=1, so seg goes 60 -> 0 -> 1 on consecutive cycles.
  - up_seg and down_seg pulses are dropped.
- carry is high iff state==CARRY.
- seg never holds SEC_WRAP for two consecutive cycles. This prevents a double minute increment downstream.
- Reset asserted mid-CARRY forces seg=0 with no carry.
- Arithmetic is on a 6-bit internal counter zero-extended to 32 bits. seg never exceeds SEC_WRAP.

Optional Feature:
- Macro SEG_PRESET_EN.
- When defined, adds two ports:
  - `preset_load` input 1
  - `preset_val` input 6
- preset_load has highest priority in any state:
  - seg<=min(preset_val, SEC_WRAP-1), pre<=0, pending<=0, state<=COUNT.
  - A carry in progress is cancelled and the next cycle's carry is suppressed.
  - Increment and decrement events in the load cycle are dropped.
- When undefined, these ports do not exist and behaviour is exactly as above.

Test Plan:
- Reset: PRESCALE=4, reset low mid-count with seg=37 -> seg=0, carry=0 and sec_tick=0 immediately (asynchronous), held until release.
- Free run: PRESCALE=4, enable=1 from seg=0 -> sec_tick every 4th cycle.
  - seg reaches 59, then 60 for exactly 1 cycle with carry=1, then 0.
  - Attached minute counter increments by exactly 100.
- Enable hold: enable low for 10 cycles with pre=2 -> seg and pre unchanged, no sec_tick. Resumes and ticks 2 cycles after enable rises.
- Adjust wrap: seg=0 + down_seg -> seg=59, no carry. seg=59 + up_seg -> 60 (carry) then 0.
- Adjust in the same cycle as a tick counts once: seg=10 -> 11.
- CARRY collision: up_seg drives seg=59 -> 60 in the same cycle the prescaler expires -> seg sequence 60, 0, 1. up_seg/down_seg asserted during CARRY have no effect.
- SEG_PRESET_EN build: preset_load with preset_val=63 during CARRY -> seg=59, carry low the next cycle, pre=0.

Source files
------------

// File: rtl/segmod.sv
// segmod: seconds counter and minute-carry source.
// Divides clk down to a once-per-second tick, counts seconds 0..SEC_WRAP-1,
// shows SEC_WRAP on seg for a single cycle as the minute carry, and takes
// manual +1/-1 second adjust pulses.
// Optional build macro SEG_PRESET_EN adds a preset_load/preset_val port pair.
//
// state | meaning
// ------+--------------------------------------------------------------
// COUNT | normal counting, seg in 0..SEC_WRAP-1
// CARRY | one cycle with seg==SEC_WRAP, carry high; tick here is deferred
module segmod #(
   parameter int PRESCALE = 10000,
   parameter int SEC_WRAP = 60
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        up_seg,
   input  logic        down_seg,
`ifdef SEG_PRESET_EN
   input  logic        preset_load,
   input  logic [5:0]  preset_val,
`endif
   output logic [31:0] seg,
   output logic        sec_tick,
   output logic        carry
);

   localparam int PW = $clog2(PRESCALE);
   localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
   localparam logic [5:0]    WRAP     = 6'(SEC_WRAP);
   localparam logic [5:0]    LAST     = 6'(SEC_WRAP - 1);

   typedef enum logic {COUNT = 1'b0, CARRY = 1'b1} state_t;

   state_t        state, state_nxt;
   logic [PW-1:0] pre;
   logic [5:0]    cnt, cnt_nxt;
   logic          pending, pending_nxt;
   logic          tick;
   logic          inc;
   logic          load;
   logic [5:0]    load_val;

`ifdef SEG_PRESET_EN
   // Preset is clamped to the last normal count so a load never fakes a carry.
   assign load     = preset_load;
   assign load_val = (preset_val > LAST) ? LAST : preset_val;
`else
   assign load     = 1'b0;
   assign load_val = 6'd0;
`endif

   assign tick = enable && (pre == PRE_LAST);
   assign inc  = tick || up_seg || pending;

   // Prescaler and registered second strobe.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pre      <= '0;
         sec_tick <= 1'b0;
      end else begin
         sec_tick <= tick;
         if (load || tick)
            pre <= '0;
         else if (enable)
            pre <= pre + 1'b1;
      end
   end

   // State, seconds count and deferred-tick flag.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= COUNT;
         cnt     <= 6'd0;
         pending <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         pending <= pending_nxt;
      end
   end

   // Next-state and next-count decode; preset overrides everything.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      pending_nxt = pending;
      if (load) begin
         state_nxt   = COUNT;
         cnt_nxt     = load_val;
         pending_nxt = 1'b0;
      end else begin
         case (state)
            COUNT: begin
               if (inc) begin
                  pending_nxt = 1'b0;
                  if (cnt == LAST) begin
                     cnt_nxt   = WRAP;
                     state_nxt = CARRY;
                  end else begin
                     cnt_nxt = cnt + 6'd1;
                  end
               end else if (down_seg) begin
                  cnt_nxt = (cnt == 6'd0) ? LAST : cnt - 6'd1;
               end
            end
            CARRY: begin
               // Adjust pulses are ignored here; a tick is remembered so the
               // second is not lost.
               cnt_nxt   = 6'd0;
               state_nxt = COUNT;
               if (tick)
                  pending_nxt = 1'b1;
            end
            default: begin
               cnt_nxt   = 6'd0;
               state_nxt = COUNT;
            end
         endcase
      end
   end

   // Outputs decoded from the current state and count.
   always_comb begin
      carry = (state == CARRY);
      seg   = {26'd0, cnt};
   end

endmodule

// File: tb/tb_segmod.sv
// Self-checking bench for segmod with PRESCALE=4, SEC_WRAP=60.
// Define SEG_PRESET_EN to also exercise the preset ports.
module tb_segmod;

   localparam int P = 4;
   localparam int W = 60;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic        up_seg;
   logic        down_seg;
   logic [31:0] seg;
   logic        sec_tick;
   logic        carry;
`ifdef SEG_PRESET_EN
   logic        preset_load;
   logic [5:0]  preset_val;
`endif

   always #5 clk = ~clk;

   segmod #(.PRESCALE(P), .SEC_WRAP(W)) dut (
      .clk      (clk),
      .reset    (reset),
      .enable   (enable),
      .up_seg   (up_seg),
      .down_seg (down_seg),
`ifdef SEG_PRESET_EN
      .preset_load (preset_load),
      .preset_val  (preset_val),
`endif
      .seg      (seg),
      .sec_tick (sec_tick),
      .carry    (carry)
   );

   int n_pass  = 0;
   int n_total = 0;

   // Reference model: seconds as an integer, prescaler phase, carry flag.
   int m_seg, m_pre, m_pend;
   bit m_carry, m_stick;

   typedef struct {
      bit en; bit up; bit dn;
      int seg; int car; int tk;
   } vec_t;
   vec_t tbl[14];

   task automatic check(string name, int got, int want);
      n_total++;
      if (got == want) n_pass++;
      else $display("FAIL %s got %0d want %0d at %0t", name, got, want, $time);
   endtask

   task automatic model_reset();
      m_seg = 0; m_pre = 0; m_pend = 0; m_carry = 0; m_stick = 0;
   endtask

   task automatic model_step(bit en, bit up, bit dn, bit pl, int pv);
      bit t;
      t = en && (m_pre == P - 1);
      if (en) m_pre = (m_pre + 1) % P;
      m_stick = t;
      if (pl) begin
         m_seg = (pv > W - 1) ? W - 1 : pv;
         m_pre = 0; m_pend = 0; m_carry = 0;
      end else if (m_carry) begin
         m_seg = 0; m_carry = 0;
         if (t) m_pend = 1;
      end else if (t || up || m_pend != 0) begin
         m_pend = 0;
         m_seg = m_seg + 1;
         if (m_seg == W) m_carry = 1;
      end else if (dn) begin
         m_seg = (m_seg + W - 1) % W;
      end
   endtask

   task automatic cyc(bit en, bit up, bit dn, bit pl = 0, int pv = 0);
      @(negedge clk);
      enable = en; up_seg = up; down_seg = dn;
`ifdef SEG_PRESET_EN
      preset_load = pl; preset_val = 6'(pv);
`endif
      @(posedge clk);
      model_step(en, up, dn, pl, pv);
      #1;
      check("seg", int'(seg), m_seg);
      check("carry", int'(carry), int'(m_carry));
      check("sec_tick", int'(sec_tick), int'(m_stick));
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0; enable = 1'b0; up_seg = 1'b0; down_seg = 1'b0;
`ifdef SEG_PRESET_EN
      preset_load = 1'b0; preset_val = 6'd0;
`endif
      model_reset();
      repeat (2) @(negedge clk);
      check("rst_seg", int'(seg), 0);
      check("rst_carry", int'(carry), 0);
      check("rst_tick", int'(sec_tick), 0);
      reset = 1'b1;
   endtask

   // Park seg at a target with the prescaler frozen, using down pulses.
   task automatic set_seg(int target);
      for (int k = 0; k < 70 && (m_seg != target || m_carry); k++) begin
         if (m_carry) cyc(0, 0, 0);
         else cyc(0, 0, 1);
      end
      check("set_seg", int'(seg), target);
   endtask

   initial begin
      int saved, n60, dbl, cnt_t;
      bit prev60, seen;

      tbl[0]  = '{0, 0, 1, 59, 0, 0};
      tbl[1]  = '{0, 1, 0, 60, 1, 0};
      tbl[2]  = '{0, 1, 1,  0, 0, 0};
      tbl[3]  = '{0, 1, 0,  1, 0, 0};
      tbl[4]  = '{0, 1, 1,  2, 0, 0};
      tbl[5]  = '{0, 0, 1,  1, 0, 0};
      tbl[6]  = '{1, 0, 0,  1, 0, 0};
      tbl[7]  = '{1, 0, 0,  1, 0, 0};
      tbl[8]  = '{1, 0, 0,  1, 0, 0};
      tbl[9]  = '{1, 0, 0,  2, 0, 1};
      tbl[10] = '{1, 1, 0,  3, 0, 0};
      tbl[11] = '{1, 0, 0,  3, 0, 0};
      tbl[12] = '{1, 0, 0,  3, 0, 0};
      tbl[13] = '{1, 1, 0,  4, 0, 1};

      reset = 1'b0;
      do_reset();

      // Directed table from reset: wraps, dropped pulses, tick+up once.
      for (int i = 0; i < 14; i++) begin
         cyc(tbl[i].en, tbl[i].up, tbl[i].dn);
         check($sformatf("vec%0d_seg", i), int'(seg), tbl[i].seg);
         check($sformatf("vec%0d_carry", i), int'(carry), tbl[i].car);
         check($sformatf("vec%0d_tick", i), int'(sec_tick), tbl[i].tk);
      end

      // Asynchronous reset just after a tick took seg to 37.
      do_reset();
      repeat (3) cyc(1, 0, 0);
      set_seg(36);
      cyc(1, 0, 0);
      check("pre_rst_seg", int'(seg), 37);
      check("pre_rst_tick", int'(sec_tick), 1);
      #2 reset = 1'b0;
      #1;
      check("async_seg", int'(seg), 0);
      check("async_carry", int'(carry), 0);
      check("async_tick", int'(sec_tick), 0);
      repeat (3) @(posedge clk);
      #1 check("held_seg", int'(seg), 0);
      model_reset();
      @(negedge clk) reset = 1'b1;
      cyc(1, 0, 0);

      // Enable hold with prescaler at 2.
      do_reset();
      repeat (2) cyc(1, 0, 0);
      saved = int'(seg);
      for (int i = 0; i < 10; i++) begin
         cyc(0, 0, 0);
         check("hold_seg", int'(seg), saved);
         check("hold_tick", int'(sec_tick), 0);
      end
      cnt_t = 0; seen = 0;
      for (int i = 0; i < 8 && !seen; i++) begin
         cyc(1, 0, 0);
         cnt_t++;
         seen = sec_tick;
      end
      check("resume_lat", cnt_t, 2);

      // Collision A: up at 59 in the same cycle the prescaler expires.
      do_reset();
      repeat (3) cyc(1, 0, 0);
      set_seg(59);
      cyc(1, 1, 0);
      check("colA_60", int'(seg), 60);
      check("colA_car", int'(carry), 1);
      cyc(1, 1, 1);
      check("colA_0", int'(seg), 0);
      check("colA_car0", int'(carry), 0);

      // Collision B: tick lands in the CARRY cycle -> 60, 0, 1.
      do_reset();
      repeat (2) cyc(1, 0, 0);
      set_seg(59);
      cyc(1, 1, 0);
      check("colB_60", int'(seg), 60);
      cyc(1, 0, 1);
      check("colB_0", int'(seg), 0);
      cyc(1, 0, 0);
      check("colB_1", int'(seg), 1);

`ifdef SEG_PRESET_EN
      // Preset during CARRY cancels it and restarts the prescaler.
      do_reset();
      set_seg(59);
      cyc(0, 1, 0);
      check("pl_car", int'(carry), 1);
      cyc(1, 1, 1, 1, 63);
      check("pl_seg", int'(seg), 59);
      check("pl_car0", int'(carry), 0);
      cnt_t = 0; seen = 0;
      for (int i = 0; i < 8 && !seen; i++) begin
         cyc(1, 0, 0);
         cnt_t++;
         seen = sec_tick;
      end
      check("pl_pre0", cnt_t, P);
`endif

      // Free run: 100 minutes of carries, never two 60s in a row.
      do_reset();
      n60 = 0; dbl = 0; prev60 = 0;
      for (int i = 0; i < 100 * W * P + 2; i++) begin
         cyc(1, 0, 0);
         if (seg == 32'(W)) begin
            n60++;
            if (prev60) dbl++;
         end
         prev60 = (seg == 32'(W));
      end
      check("minutes", n60, 100);
      check("double60", dbl, 0);

      // Randomised traffic against the model.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         bit en, up, dn, pl;
         en = ($urandom_range(0, 3) != 0);
         up = ($urandom_range(0, 7) == 0);
         dn = ($urandom_range(0, 7) == 0);
`ifdef SEG_PRESET_EN
         pl = ($urandom_range(0, 31) == 0);
`else
         pl = 1'b0;
`endif
         cyc(en, up, dn, pl, int'($urandom_range(0, 63)));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
